// File: rtl/bpm_sequencer.sv
// Beat-interval sequencer: screens measured intervals, feeds BPM_Calculator one at a time,
// handles its result handshake and launches one UART byte per BPM result.
module bpm_sequencer #(
    parameter int WIDTH   = 6,
    parameter int MIN_INT = 10,
    parameter int MAX_INT = 63,
    parameter int TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic [WIDTH-1:0] interval_count,
    input  logic             interval_valid,
    output logic             calc_en,
    output logic [WIDTH-1:0] calc_interval,
    output logic             calc_valid,
    input  logic [7:0]       calc_bpm,
    input  logic             calc_bpm_valid,
    output logic             calc_bpm_copied,
    output logic [7:0]       tx_data,
    output logic             tx_start,
    input  logic             tx_busy,
    input  logic             tx_done,
    output logic [7:0]       bpm_latest,
    output logic             busy,
    output logic [7:0]       drop_count,
    output logic [7:0]       reject_count,
    output logic             err_timeout
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_ISSUE     = 3'd1;
    localparam logic [2:0] S_WAIT_CALC = 3'd2;
    localparam logic [2:0] S_COPY      = 3'd3;
    localparam logic [2:0] S_TX_REQ    = 3'd4;
    localparam logic [2:0] S_TX_WAIT   = 3'd5;

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0]    CNT_LAST = CW'(TIMEOUT - 1);
    localparam logic [WIDTH-1:0] MIN_V    = WIDTH'(MIN_INT);
    localparam logic [WIDTH-1:0] MAX_V    = WIDTH'(MAX_INT);

    logic [2:0]       state_reg, state_next;
    logic [CW-1:0]    cnt_reg, cnt_next;
    logic             pend_full_reg, pend_full_next;
    logic [WIDTH-1:0] pend_val_reg, pend_val_next;
    logic [WIDTH-1:0] calc_interval_reg, calc_interval_next;
    logic [7:0]       tx_data_reg, tx_data_next;
    logic [7:0]       bpm_latest_reg, bpm_latest_next;
    logic [7:0]       drop_reg, drop_next;
    logic [7:0]       reject_reg, reject_next;
    logic             err_reg, err_next;

    logic in_range, accept, reject, drop_inc;

    assign in_range = (interval_count >= MIN_V) && (interval_count <= MAX_V);
    assign accept   = interval_valid && enable && in_range;
    assign reject   = interval_valid && enable && !in_range;

    always_comb begin
        state_next         = state_reg;
        cnt_next           = cnt_reg;
        pend_full_next     = pend_full_reg;
        pend_val_next      = pend_val_reg;
        calc_interval_next = calc_interval_reg;
        tx_data_next       = tx_data_reg;
        bpm_latest_next    = bpm_latest_reg;
        err_next           = err_reg;
        drop_inc           = 1'b0;

        // Intake: in IDLE a fresh interval pre-empts any pending one; elsewhere it
        // lands in the one-deep buffer, newest overwriting oldest.
        if (state_reg == S_IDLE) begin
            if (accept) begin
                calc_interval_next = interval_count;
                state_next         = S_ISSUE;
                if (pend_full_reg) begin
                    pend_full_next = 1'b0;
                    drop_inc       = 1'b1;
                end
            end else if (pend_full_reg && enable) begin
                calc_interval_next = pend_val_reg;
                pend_full_next     = 1'b0;
                state_next         = S_ISSUE;
            end
        end else if (accept) begin
            pend_val_next  = interval_count;
            pend_full_next = 1'b1;
            drop_inc       = pend_full_reg;
        end

        case (state_reg)
            S_ISSUE: begin
                cnt_next   = '0;
                state_next = S_WAIT_CALC;
            end
            S_WAIT_CALC: begin
                if (calc_bpm_valid) begin
                    tx_data_next    = calc_bpm;
                    bpm_latest_next = calc_bpm;
                    state_next      = S_COPY;
                end else if (cnt_reg == CNT_LAST) begin
                    err_next   = 1'b1;
                    state_next = S_IDLE;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            S_COPY:    state_next = S_TX_REQ;
            S_TX_REQ:  if (!tx_busy) state_next = S_TX_WAIT;
            S_TX_WAIT: if (tx_done) state_next = S_IDLE;
            default:   ;
        endcase

        drop_next   = (drop_inc && drop_reg != 8'hFF) ? drop_reg + 8'd1 : drop_reg;
        reject_next = (reject && reject_reg != 8'hFF) ? reject_reg + 8'd1 : reject_reg;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg         <= S_IDLE;
            cnt_reg           <= '0;
            pend_full_reg     <= 1'b0;
            pend_val_reg      <= '0;
            calc_interval_reg <= '0;
            tx_data_reg       <= 8'd0;
            bpm_latest_reg    <= 8'd0;
            drop_reg          <= 8'd0;
            reject_reg        <= 8'd0;
            err_reg           <= 1'b0;
        end else begin
            state_reg         <= state_next;
            cnt_reg           <= cnt_next;
            pend_full_reg     <= pend_full_next;
            pend_val_reg      <= pend_val_next;
            calc_interval_reg <= calc_interval_next;
            tx_data_reg       <= tx_data_next;
            bpm_latest_reg    <= bpm_latest_next;
            drop_reg          <= drop_next;
            reject_reg        <= reject_next;
            err_reg           <= err_next;
        end
    end

    assign calc_en         = (state_reg == S_ISSUE) || (state_reg == S_WAIT_CALC) ||
                             (state_reg == S_COPY);
    assign calc_valid      = (state_reg == S_ISSUE);
    assign calc_bpm_copied = (state_reg == S_COPY);
    // Launch falls in the first TX_REQ cycle the UART is free; the FSM leaves on that edge.
    assign tx_start        = (state_reg == S_TX_REQ) && !tx_busy;
    assign busy            = (state_reg != S_IDLE);
    assign calc_interval   = calc_interval_reg;
    assign tx_data         = tx_data_reg;
    assign bpm_latest      = bpm_latest_reg;
    assign drop_count      = drop_reg;
    assign reject_count    = reject_reg;
    assign err_timeout     = err_reg;

endmodule

// File: tb/tb_bpm_sequencer.sv
// Scoreboard bench for bpm_sequencer with behavioural calculator and UART models.
module tb_bpm_sequencer;

    localparam int WIDTH   = 6;
    localparam int TIMEOUT = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             enable;
    logic [WIDTH-1:0] interval_count;
    logic             interval_valid;
    logic             calc_en;
    logic [WIDTH-1:0] calc_interval;
    logic             calc_valid;
    logic [7:0]       calc_bpm;
    logic             calc_bpm_valid;
    logic             calc_bpm_copied;
    logic [7:0]       tx_data;
    logic             tx_start;
    logic             tx_busy;
    logic             tx_done;
    logic [7:0]       bpm_latest;
    logic             busy;
    logic [7:0]       drop_count;
    logic [7:0]       reject_count;
    logic             err_timeout;

    bpm_sequencer #(.WIDTH(WIDTH), .MIN_INT(10), .MAX_INT(40), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .enable(enable),
        .interval_count(interval_count), .interval_valid(interval_valid),
        .calc_en(calc_en), .calc_interval(calc_interval), .calc_valid(calc_valid),
        .calc_bpm(calc_bpm), .calc_bpm_valid(calc_bpm_valid), .calc_bpm_copied(calc_bpm_copied),
        .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy), .tx_done(tx_done),
        .bpm_latest(bpm_latest), .busy(busy), .drop_count(drop_count),
        .reject_count(reject_count), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int n_calc_valid = 0;
    int n_tx_start = 0;
    int n_copied = 0;

    logic [WIDTH-1:0] exp_calc[$];
    logic [7:0]       exp_tx[$];

    bit       calc_respond = 1'b1;
    int       calc_delay   = 3;
    logic [7:0] calc_result = 8'd0;
    int       tx_delay     = 5;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end else begin
            $display("ok   %s: %0h", tag, obs);
        end
    endtask

    // Scoreboard: every calculator issue and every UART launch is matched against the queues.
    always @(negedge clk) begin
        if (!rst) begin
            if (calc_valid) begin
                n_calc_valid++;
                check("calc_expected", exp_calc.size() > 0, 1);
                if (exp_calc.size() > 0) check("calc_interval", calc_interval, exp_calc.pop_front());
            end
            if (tx_start) begin
                n_tx_start++;
                check("tx_expected", exp_tx.size() > 0, 1);
                if (exp_tx.size() > 0) check("tx_data", tx_data, exp_tx.pop_front());
            end
            if (calc_bpm_copied) n_copied++;
        end
    end

    initial begin
        calc_bpm_valid = 1'b0;
        calc_bpm = 8'd0;
        forever begin
            @(negedge clk);
            if (calc_valid && calc_respond && !rst) begin
                repeat (calc_delay) @(posedge clk);
                #1;
                calc_bpm = calc_result;
                calc_bpm_valid = 1'b1;
                exp_tx.push_back(calc_result);
                for (int k = 0; k < 40; k++) begin
                    @(negedge clk);
                    if (calc_bpm_copied) break;
                end
                @(posedge clk);
                #1 calc_bpm_valid = 1'b0;
            end
        end
    end

    initial begin
        tx_done = 1'b0;
        forever begin
            @(negedge clk);
            if (tx_start && !rst) begin
                repeat (tx_delay) @(posedge clk);
                #1 tx_done = 1'b1;
                @(posedge clk);
                #1 tx_done = 1'b0;
            end
        end
    end

    task automatic send(input logic [WIDTH-1:0] v);
        @(posedge clk);
        #1 interval_count = v;
        interval_valid = 1'b1;
        @(posedge clk);
        #1 interval_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (!busy) break;
        end
        check(tag, busy, 0);
    endtask

    task automatic wait_tx(input string tag, input int target);
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (n_tx_start >= target) break;
        end
        check(tag, n_tx_start >= target, 1);
    endtask

    initial begin
        int base_cv, base_tx, base_cp, hits;
        rst = 1'b1; enable = 1'b0; interval_count = '0; interval_valid = 1'b0; tx_busy = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_calc_en", calc_en, 0);
        check("rst_calc_valid", calc_valid, 0);
        check("rst_calc_interval", calc_interval, 0);
        check("rst_tx_start", tx_start, 0);
        check("rst_tx_data", tx_data, 0);
        check("rst_bpm_latest", bpm_latest, 0);
        check("rst_counts", {drop_count, reject_count}, 0);
        check("rst_err", err_timeout, 0);
        @(posedge clk);
        #1 rst = 1'b0; enable = 1'b1;

        // Basic flow
        calc_result = 8'd60; calc_delay = 3; tx_delay = 5;
        exp_calc.push_back(6'd25);
        send(6'd25);
        @(negedge clk);
        check("basic_latency", calc_valid, 1);
        check("basic_calc_en", calc_en, 1);
        wait_idle("basic_idle");
        check("basic_copied_cycles", n_copied, 1);
        check("basic_tx_count", n_tx_start, 1);
        check("basic_bpm_latest", bpm_latest, 60);

        // Range screen, then ignored strobes while disabled
        base_cv = n_calc_valid;
        send(6'd9); send(6'd0); send(6'd41);
        repeat (2) @(negedge clk);
        check("range_reject_count", reject_count, 3);
        check("range_no_issue", n_calc_valid, base_cv);
        calc_result = 8'd100;
        exp_calc.push_back(6'd10);
        send(6'd10);
        wait_idle("range_idle");
        check("range_one_issue", n_calc_valid, base_cv + 1);
        @(posedge clk); #1 enable = 1'b0;
        send(6'd5); send(6'd20);
        repeat (3) @(negedge clk);
        check("disabled_reject_count", reject_count, 3);
        check("disabled_no_issue", n_calc_valid, base_cv + 1);
        @(posedge clk); #1 enable = 1'b1;

        // Pending buffer and drops while in TX_WAIT
        base_cv = n_calc_valid; base_tx = n_tx_start;
        calc_result = 8'd88; tx_delay = 20;
        exp_calc.push_back(6'd15);
        send(6'd15);
        wait_tx("pend_first_tx", base_tx + 1);
        send(6'd20); send(6'd30); send(6'd40);
        exp_calc.push_back(6'd40);
        @(negedge clk);
        check("pend_drop_count", drop_count, 2);
        tx_delay = 5;
        wait_tx("pend_second_tx", base_tx + 2);
        wait_idle("pend_idle");
        check("pend_issue_count", n_calc_valid, base_cv + 2);

        // Calculator timeout
        calc_respond = 1'b0;
        base_tx = n_tx_start;
        exp_calc.push_back(6'd30);
        send(6'd30);
        @(negedge clk);
        check("to_issue", calc_valid, 1);
        hits = 0;
        for (int i = 0; i < TIMEOUT; i++) begin
            @(negedge clk);
            if (err_timeout || !busy) hits++;
        end
        check("to_not_early", hits, 0);
        @(negedge clk);
        check("to_err", err_timeout, 1);
        check("to_idle", busy, 0);
        check("to_no_tx", n_tx_start, base_tx);

        // UART back-pressure
        calc_respond = 1'b1; calc_result = 8'd77; tx_busy = 1'b1;
        base_cp = n_copied; base_tx = n_tx_start;
        exp_calc.push_back(6'd33);
        send(6'd33);
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (n_copied > base_cp) break;
        end
        check("bp_copied", n_copied, base_cp + 1);
        hits = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (tx_start) hits++;
        end
        check("bp_held", hits, 0);
        @(posedge clk); #1 tx_busy = 1'b0;
        @(negedge clk);
        check("bp_launch", tx_start, 1);
        wait_idle("bp_idle");
        check("bp_tx_count", n_tx_start, base_tx + 1);
        check("to_err_sticky", err_timeout, 1);

        // Reset while waiting on the calculator
        calc_respond = 1'b0;
        base_cp = n_copied; base_tx = n_tx_start;
        exp_calc.push_back(6'd12);
        send(6'd12);
        repeat (4) @(negedge clk);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("mid_rst_outputs",
              {busy, calc_en, calc_valid, calc_bpm_copied, tx_start, err_timeout}, 0);
        check("mid_rst_values", {calc_interval, tx_data, bpm_latest, drop_count, reject_count}, 0);
        @(posedge clk); #1 rst = 1'b0;
        repeat (20) @(negedge clk);
        check("mid_rst_no_copy", n_copied, base_cp);
        check("mid_rst_no_tx", n_tx_start, base_tx);

        // Pending held while disabled, issued once enable returns
        calc_respond = 1'b1; calc_result = 8'd50; tx_delay = 10;
        base_cv = n_calc_valid; base_tx = n_tx_start;
        exp_calc.push_back(6'd22);
        send(6'd22);
        wait_tx("en_first_tx", base_tx + 1);
        exp_calc.push_back(6'd35);
        send(6'd35);
        @(posedge clk); #1 enable = 1'b0;
        wait_idle("en_first_idle");
        hits = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (calc_valid || busy) hits++;
        end
        check("en_held", hits, 0);
        @(posedge clk); #1 enable = 1'b1;
        @(negedge clk);
        check("en_not_same_cycle", calc_valid, 0);
        @(negedge clk);
        check("en_issue", calc_valid, 1);
        wait_tx("en_second_tx", base_tx + 2);
        wait_idle("en_second_idle");
        check("en_issue_count", n_calc_valid, base_cv + 2);
        check("en_bpm_latest", bpm_latest, 50);
        check("en_drop_count", drop_count, 0);
        check("queues_drained", exp_calc.size() + exp_tx.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/bpm_sequencer.md
Name: bpm_sequencer

Overview:
- Controller between the time-interval counter and BPM_Calculator, and between BPM_Calculator and the UART transmitter.
- Screens each measured beat interval against a plausible range and forwards accepted intervals to the calculator one at a time.
- Collects the BPM result, performs the bpm_valid/bpm_copied handshake on the calculator's behalf, and launches one UART byte per result.
- Buffers one pending interval while busy and reports drops, rejects and calculator timeouts.

Parameters:
- WIDTH, 6: interval_count width in samples.
- MIN_INT, 10: smallest accepted interval. At FS=25 this corresponds to 150 BPM.
- MAX_INT, 63: largest accepted interval. Must satisfy MAX_INT ≤ 2^WIDTH−1.
- TIMEOUT, 16: maximum cycles in WAIT_CALC before a timeout error is raised.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- enable  in  1  master run enable.
- interval_count  in  WIDTH  measured beat interval.
- interval_valid  in  1  1-cycle strobe qualifying interval_count.
- calc_en  out  1  enable to BPM_Calculator.
- calc_interval  out  WIDTH  interval presented to the calculator.
- calc_valid  out  1  1-cycle strobe to the calculator.
- calc_bpm  in  8  calculator result.
- calc_bpm_valid  in  1  calculator result valid (level).
- calc_bpm_copied  out  1  1-cycle acknowledge to the calculator.
- tx_data  out  8  byte to the UART.
- tx_start  out  1  1-cycle UART launch.
- tx_busy  in  1  UART busy.
- tx_done  in  1  1-cycle UART completion.
- bpm_latest  out  8  last good BPM value.
- busy  out  1  high when the FSM is not in IDLE.
- drop_count  out  8  saturating count of intervals overwritten in the pending buffer.
- reject_count  out  8  saturating count of out-of-range intervals.
- err_timeout  out  1  sticky calculator-timeout flag.

Behaviour:
- Reset:
  - All outputs are 0.
  - The pending buffer is empty and the FSM is in IDLE.
  - Reset mid-transaction aborts immediately. No tx_start or calc_bpm_copied is issued afterwards.
- Acceptance:
  - An interval is accepted when interval_valid=1, enable=1 and MIN_INT ≤ interval_count ≤ MAX_INT.
  - interval_valid=1 with enable=1 but out of range: reject_count increments, saturating at 255. Nothing else changes.
  - interval_valid=1 with enable=0: ignored and not counted.
- FSM states: IDLE, ISSUE, WAIT_CALC, COPY, TX_REQ, TX_WAIT.
- IDLE:
  - An accepted input goes to ISSUE with that value.
  - If the pending buffer is also full in the same cycle, the incoming value wins, pending is cleared, and drop_count increments.
  - Otherwise, if pending is full and enable=1, go to ISSUE with the pending value and clear pending.
- ISSUE (1 cycle):
  - calc_valid=1 and calc_interval is held.
  - Go to WAIT_CALC.
  - Latency: acceptance in cycle N gives calc_valid in cycle N+1.
- calc_en: 1 in ISSUE, WAIT_CALC and COPY; 0 elsewhere.
- WAIT_CALC:
  - A cycle counter starts at 0.
  - On calc_bpm_valid=1: latch calc_bpm into tx_data and bpm_latest, then go to COPY.
  - If the counter reaches TIMEOUT−1 without calc_bpm_valid: set err_timeout=1 (cleared only by rst), discard the result, return to IDLE.
- COPY (1 cycle):
  - calc_bpm_copied=1.
  - Go to TX_REQ.
- TX_REQ:
  - Wait while tx_busy=1.
  - When tx_busy=0, drive tx_start=1 for 1 cycle and go to TX_WAIT.
- TX_WAIT:
  - Wait for tx_done=1, then go to IDLE.
  - A pending value is issued on the next cycle via IDLE.
- Pending buffer (1 deep):
  - An accepted interval arriving while not in IDLE is stored if the buffer is empty.
  - If the buffer is full, it is overwritten (newest wins) and drop_count increments.
- enable deasserted mid-transaction:
  - The current transaction completes normally.
  - Pending is retained but not issued until enable=1.
- Counters: drop_count and reject_count saturate at 255 and never wrap.
- bpm_latest holds its value until the next successful result.

Test Plan:
- Basic flow:
  - Stimulus: rst 2 cycles; enable=1; interval_count=25 with interval_valid pulse; calculator model returns 60 after 3 cycles; UART returns tx_done 5 cycles after tx_start.
  - Required: calc_valid exactly 1 cycle after the strobe; calc_bpm_copied 1 cycle; tx_start 1 cycle with tx_data=60; bpm_latest=60; busy returns to 0.
- Range screen:
  - Stimulus: intervals 9, 0, 64-equivalent (63+1 not representable, so use MAX_INT=40 and send 41), then 10.
  - Required: reject_count=3; only interval 10 produces calc_valid.
- Pending and drop:
  - Stimulus: while in TX_WAIT send intervals 20, 30, 40.
  - Required: drop_count=2; after tx_done, calc_interval=40 is issued; 20 and 30 are never issued.
- Timeout:
  - Stimulus: calculator never asserts calc_bpm_valid.
  - Required: err_timeout=1 after TIMEOUT cycles in WAIT_CALC; no tx_start; FSM back in IDLE; flag persists until rst.
- UART back-pressure:
  - Stimulus: tx_busy=1 for 10 cycles at TX_REQ entry.
  - Required: tx_start asserted only on the first cycle with tx_busy=0.
- Reset and enable:
  - Stimulus: rst asserted in WAIT_CALC.
  - Required: all outputs 0 on the next cycle; no calc_bpm_copied.
  - Stimulus: enable=0 with a pending value held.
  - Required: no issue until enable rises; calc_valid 1 cycle after enable goes high.
